// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, ALU codes,
// FSM states and the per-state Moore control word.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  typedef struct packed {
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    alu_op_e    alu_op;
    logic       fetch_en;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
  } ctrl_t;

  // fetch_en covers both ir_write and the PC+4 update; both wait on mem_ready.
  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.src_b = SRCB_FOUR; c.result_src = RES_ALU; c.fetch_en = 1'b1; end
      S_DECODE:   begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_MEMADR:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = RES_MEM; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR:    begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH:   begin c.src_a = SRCA_RS1; c.alu_op = ALUOP_SUB; c.branch = 1'b1; end
      S_JAL:      begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_FOUR; c.pc_update = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv32_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control out.
interface rv32_multicycle_ctrl_if #(parameter int STATE_W = 4);
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               zero;
  logic               mem_ready;
  logic [2:0]         alu_ctrl;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         result_src;
  logic [1:0]         imm_src;
  logic               adr_src;
  logic               ir_write;
  logic               pc_write;
  logic               reg_write;
  logic               mem_write;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output alu_ctrl, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
           ir_write, pc_write, reg_write, mem_write, illegal_op, state_o
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  alu_ctrl, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
           ir_write, pc_write, reg_write, mem_write, illegal_op, state_o
  );
endinterface

// File: rtl/rv32_alu_decoder.sv
// Maps the controller's ALU operation class plus funct fields to the CS code.
module rv32_alu_decoder
  import rv32_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_ctrl
);

  // op5 separates R-type from I-ALU so addi with instr[30] set stays an add.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I main controller for lw/sw/R/I-ALU/beq/bne/jal.
//
// state    | meaning
// FETCH    | read instr at PC, PC+4 -> PC when mem_ready
// DECODE   | oldPC+imm -> ALUOut (branch/jal target), dispatch on opcode
// MEMADR   | rs1+imm effective address
// MEMREAD  | load access at ALUOut, wait mem_ready
// MEMWB    | load data -> rd
// MEMWRITE | store access at ALUOut, mem_write held until mem_ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | ALUOut -> rd
// BRANCH   | rs1-rs2, redirect PC on taken
// JAL      | target -> PC, oldPC+4 computed for link
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter bit SUPPORT_BNE = 1'b1,
  parameter int STATE_W     = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  rv32_multicycle_ctrl_if.master bus
);

  state_e state, state_d;
  ctrl_t  ctrl_q;
  logic   illegal;
  logic   taken;

  always_comb begin
    illegal = 1'b1;
    case (bus.opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_JAL: illegal = 1'b0;
      OP_BRANCH: illegal = !((bus.funct3 == 3'b000) || ((bus.funct3 == 3'b001) && SUPPORT_BNE));
      default:   illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        if (!illegal) begin
          case (bus.opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECR;
            OP_IALU:      state_d = S_EXECI;
            OP_BRANCH:    state_d = S_BRANCH;
            OP_JAL:       state_d = S_JAL;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so every Moore output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH);
    end else begin
      state  <= state_d;
      ctrl_q <= state_ctrl(state_d);
    end
  end

  assign taken = bus.funct3[0] ? ~bus.zero : bus.zero;

  // rst_n gating keeps the FETCH enables low while reset is held.
  assign bus.ir_write   = rst_n & ctrl_q.fetch_en & bus.mem_ready;
  assign bus.pc_write   = rst_n & ((ctrl_q.fetch_en & bus.mem_ready) | ctrl_q.pc_update
                                   | (ctrl_q.branch & taken));
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.adr_src    = ctrl_q.adr_src;
  assign bus.alu_src_a  = ctrl_q.src_a;
  assign bus.alu_src_b  = ctrl_q.src_b;
  assign bus.result_src = ctrl_q.result_src;
  assign bus.illegal_op = (state == S_DECODE) & illegal;
  assign bus.state_o    = STATE_W'(state);

  always_comb begin
    case (bus.opcode)
      OP_SW:     bus.imm_src = IMM_S;
      OP_BRANCH: bus.imm_src = IMM_B;
      OP_JAL:    bus.imm_src = IMM_J;
      default:   bus.imm_src = IMM_I;
    endcase
  end

  rv32_alu_decoder u_alu_decoder (
    .alu_op   (ctrl_q.alu_op),
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .op5      (bus.opcode[5]),
    .alu_ctrl (bus.alu_ctrl)
  );

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed + randomized bench for rv32_multicycle_ctrl against an instruction-level model.
module tb_rv32_multicycle_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   m_state;

  logic [31:0] last_state;
  logic [2:0]  last_alu;
  logic [1:0]  last_rs;
  logic        last_mw, last_rw, last_pcw, last_ill, last_ir;

  rv32_multicycle_ctrl_if #(.STATE_W(4)) bus ();

  rv32_multicycle_ctrl #(.SUPPORT_BNE(1'b1), .STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  function automatic logic model_illegal(logic [6:0] op, logic [2:0] f3);
    if (op == BR) return !(f3 == 3'd0 || f3 == 3'd1);
    return !(op == LW || op == SW || op == RT || op == IA || op == JL);
  endfunction

  function automatic int model_next(int s, logic [6:0] op, logic [2:0] f3, logic mr);
    case (s)
      0: return mr ? 1 : 0;
      1: begin
        if (model_illegal(op, f3)) return 0;
        if (op == LW || op == SW) return 2;
        if (op == RT) return 6;
        if (op == IA) return 7;
        if (op == BR) return 9;
        return 10;
      end
      2: return (op == LW) ? 3 : 5;
      3: return mr ? 4 : 3;
      5: return mr ? 0 : 5;
      6, 7, 10: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] model_alu(logic [6:0] op, logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return (f7 && op[5]) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // {alu_ctrl, src_a, src_b, result_src, imm_src, adr_src, ir_write, pc_write, reg_write, mem_write, illegal_op}
  function automatic logic [16:0] model_out(int s, logic [6:0] op, logic [2:0] f3, logic f7,
                                            logic z, logic mr);
    logic [2:0] alu;
    logic [1:0] a, b, rs, imm;
    logic adr, ir, pcw, rw, mw, ill;
    alu = 0; a = 0; b = 0; rs = 0; adr = 0; ir = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
    if (op == SW) imm = 2'd1;
    else if (op == BR) imm = 2'd2;
    else if (op == JL) imm = 2'd3;
    else imm = 2'd0;
    case (s)
      0: begin b = 2; rs = 2; ir = mr; pcw = mr; end
      1: begin a = 1; b = 1; ill = model_illegal(op, f3); end
      2: begin a = 2; b = 1; end
      3: adr = 1;
      4: begin rs = 1; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin a = 2; alu = model_alu(op, f3, f7); end
      7: begin a = 2; b = 1; alu = model_alu(op, f3, f7); end
      8: rw = 1;
      9: begin a = 2; alu = 3'b001; pcw = (f3 == 3'd1) ? !z : z; end
      10: begin a = 1; b = 2; pcw = 1; end
      default: ;
    endcase
    return {alu, a, b, rs, imm, adr, ir, pcw, rw, mw, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cyc(input logic mr, input logic z);
    logic [16:0] dut_v;
    bus.mem_ready = mr;
    bus.zero = z;
    #1;
    dut_v = {bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src,
             bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.illegal_op};
    last_state = 32'(bus.state_o);
    last_alu = bus.alu_ctrl; last_rs = bus.result_src; last_mw = bus.mem_write;
    last_rw = bus.reg_write; last_pcw = bus.pc_write; last_ill = bus.illegal_op;
    last_ir = bus.ir_write;
    chk("state", last_state, 32'(m_state));
    chk("outputs", 32'(dut_v), 32'(model_out(m_state, bus.opcode, bus.funct3, bus.funct7b5, z, mr)));
    @(posedge clk);
    m_state = model_next(m_state, bus.opcode, bus.funct3, mr);
    @(negedge clk);
  endtask

  task automatic exec_alu(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [2:0] exp);
    set_instr(op, f3, f7);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      if (i == 2) chk(name, 32'(last_alu), 32'(exp));
    end
  endtask

  task automatic branch(input string name, input logic [2:0] f3, input logic z, input logic exp);
    set_instr(BR, f3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, z);
      if (i == 2) chk(name, 32'(last_pcw), 32'(exp));
    end
  endtask

  initial begin
    int lw_seq [5] = '{0, 1, 2, 3, 4};
    int mw_cnt;
    checks = 0;
    errors = 0;
    m_state = 0;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    set_instr(LW, 3'd2, 1'b0);
    #12;
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_enables", 32'({bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.illegal_op}), 32'd0);
    chk("rst_selects", 32'({bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctrl}),
        32'({1'b0, 2'b00, 2'b10, 2'b10, 3'b000}));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      chk("lw_seq", last_state, 32'(lw_seq[i]));
      if (i == 4) chk("lw_memwb", 32'({last_rw, last_rs}), 32'({1'b1, 2'b01}));
      else chk("lw_no_rw", 32'(last_rw), 32'd0);
    end

    exec_alu("r_sub", RT, 3'd0, 1'b1, 3'b001);
    exec_alu("r_and", RT, 3'd7, 1'b0, 3'b100);
    exec_alu("r_slt", RT, 3'd2, 1'b0, 3'b101);
    exec_alu("r_or", RT, 3'd6, 1'b1, 3'b011);
    exec_alu("addi_f7", IA, 3'd0, 1'b1, 3'b000);

    branch("beq_z1", 3'd0, 1'b1, 1'b1);
    branch("beq_z0", 3'd0, 1'b0, 1'b0);
    branch("bne_z1", 3'd1, 1'b1, 1'b0);
    branch("bne_z0", 3'd1, 1'b0, 1'b1);

    set_instr(SW, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    mw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, 1'b0);
      if (last_mw) mw_cnt++;
    end
    chk("sw_mw_cycles", 32'(mw_cnt), 32'd4);
    cyc(1'b0, 1'b0);
    chk("sw_then_fetch", last_state, 32'd0);

    set_instr(7'b1111111, 3'd0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("illegal_pulse", 32'(last_ill), 32'd1);
    cyc(1'b0, 1'b0);
    chk("illegal_to_fetch", 32'({last_state[3:0], last_ill}), 32'd0);

    set_instr(BR, 3'd2, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("br_f3_illegal", 32'(last_ill), 32'd1);
    cyc(1'b0, 1'b0);

    set_instr(JL, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      if (i == 2) chk("jal_pcw", 32'({last_state[3:0], last_pcw}), 32'({4'd10, 1'b1}));
    end

    set_instr(SW, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("mw_before_rst", 32'(last_mw), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mw", 32'(bus.mem_write), 32'd0);
    chk("rst_mid_state", 32'(bus.state_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_state = 0;

    for (int n = 0; n < 800; n++) begin
      if (m_state == 0) begin
        case ($urandom_range(0, 6))
          0: bus.opcode = LW;
          1: bus.opcode = SW;
          2: bus.opcode = RT;
          3: bus.opcode = IA;
          4: bus.opcode = BR;
          5: bus.opcode = JL;
          default: bus.opcode = 7'($urandom);
        endcase
        bus.funct3 = 3'($urandom);
        bus.funct7b5 = 1'($urandom);
      end
      cyc($urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
